// File: rtl/dual_port_mem_model.sv
// dual_port_mem_model
//   Byte-addressed, little-endian memory model with an instruction fetch
//   port and a data read/write port. Both read ports have a configurable,
//   fully pipelined latency. Data writes use byte enables. A read and a
//   write on the data port at the same edge is a collision: the write
//   wins and d_err pulses. Contents live in the byte array `mem`, which
//   the bench can preload hierarchically. Reset does not clear `mem`.
//
// Ports
//   mem_clk   : clock, all state changes on its rising edge
//   nreset    : asynchronous active-low reset
//   i_en      : fetch request            i_addr  : fetch byte address
//   i_rdata   : fetched word             i_valid : i_rdata updated this cycle
//   d_read    : data read request        d_write : data write request
//   d_addr    : data byte address        d_wdata : write data
//   d_be      : per-byte-lane write enables
//   d_rdata   : read data                d_valid : d_rdata updated this cycle
//   d_err     : one-cycle pulse after a read/write collision
//   wr_count  : accepted (non-empty) writes since reset, wraps at 2**32
module dual_port_mem_model #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RD_LAT      = 1,
    parameter logic [31:0] RESET_INSTR = 32'hC8000000
) (
    input  logic                mem_clk,
    input  logic                nreset,
    input  logic                i_en,
    input  logic [31:0]         i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_valid,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic                d_err,
    output logic [31:0]         wr_count
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [DATA_W-1:0] RST_I = DATA_W'(RESET_INSTR);

    logic [7:0] mem [DEPTH];

    logic [DATA_W-1:0] i_word;
    logic [DATA_W-1:0] d_word;

    logic [DATA_W-1:0] i_pipe [RD_LAT];
    logic [DATA_W-1:0] d_pipe [RD_LAT];
    logic [RD_LAT-1:0] i_pvld;
    logic [RD_LAT-1:0] d_pvld;
    logic              coll_q;

    // Only the low ADDR_W address bits select a byte.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

    // Word assembly; the index sum is ADDR_W bits wide so a word that
    // straddles the top of memory wraps to byte 0.
    always_comb begin
        i_word = '0;
        d_word = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            i_word[8*k +: 8] = mem[i_addr[ADDR_W-1:0] + ADDR_W'(k)];
            d_word[8*k +: 8] = mem[d_addr[ADDR_W-1:0] + ADDR_W'(k)];
        end
    end

    // Reads sample i_word/d_word at the same edge that commits a write,
    // so a same-edge fetch sees the old bytes.
    always_ff @(posedge mem_clk) begin
        if (nreset && d_write) begin
            for (int unsigned k = 0; k < NB; k++) begin
                if (d_be[k]) begin
                    mem[d_addr[ADDR_W-1:0] + ADDR_W'(k)] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

    // Stage 0 captures the word at the request edge; the output register
    // adds the final cycle, giving RD_LAT edges from request to output.
    always_ff @(posedge mem_clk or negedge nreset) begin
        if (!nreset) begin
            for (int unsigned k = 0; k < RD_LAT; k++) begin
                i_pipe[k] <= '0;
                d_pipe[k] <= '0;
            end
            i_pvld   <= '0;
            d_pvld   <= '0;
            coll_q   <= 1'b0;
            i_rdata  <= RST_I;
            i_valid  <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            wr_count <= '0;
        end else begin
            i_pipe[0] <= i_word;
            d_pipe[0] <= d_word;
            i_pvld[0] <= i_en;
            d_pvld[0] <= d_read & ~d_write;
            for (int unsigned k = 1; k < RD_LAT; k++) begin
                i_pipe[k] <= i_pipe[k-1];
                d_pipe[k] <= d_pipe[k-1];
                i_pvld[k] <= i_pvld[k-1];
                d_pvld[k] <= d_pvld[k-1];
            end

            i_valid <= i_pvld[RD_LAT-1];
            if (i_pvld[RD_LAT-1]) begin
                i_rdata <= i_pipe[RD_LAT-1];
            end
            d_valid <= d_pvld[RD_LAT-1];
            if (d_pvld[RD_LAT-1]) begin
                d_rdata <= d_pipe[RD_LAT-1];
            end

            coll_q <= d_read & d_write;
            d_err  <= coll_q;

            if (d_write && (d_be != '0)) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dual_port_mem_model.sv
// tb_dual_port_mem_model
//   Drives two instances (RD_LAT=1 and RD_LAT=3) with identical stimulus.
//   Expected read data is computed from a byte-array reference model at
//   request time and filed by request cycle; a negedge monitor compares
//   every cycle for each instance.
module tb_dual_port_mem_model;

    logic        mem_clk = 1'b0;
    logic        nreset  = 1'b0;
    logic        i_en    = 1'b0;
    logic [31:0] i_addr  = '0;
    logic        d_read  = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr  = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be    = '0;

    logic [31:0] i_rdata_o  [2];
    logic        i_valid_o  [2];
    logic [31:0] d_rdata_o  [2];
    logic        d_valid_o  [2];
    logic        d_err_o    [2];
    logic [31:0] wr_count_o [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [7:0]  mdl [0:65535];
    logic [31:0] mdl_wr = '0;
    logic [31:0] i_exp [int];
    logic [31:0] d_exp [int];
    bit          e_exp [int];
    logic [31:0] last_i [2];
    logic [31:0] last_d [2];
    bit          hold_rst = 1'b1;

    dual_port_mem_model #(.ADDR_W(16), .DATA_W(32), .RD_LAT(1), .RESET_INSTR(32'hC8000000)) u_dut1 (
        .mem_clk(mem_clk), .nreset(nreset),
        .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata_o[0]), .i_valid(i_valid_o[0]),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata_o[0]), .d_valid(d_valid_o[0]), .d_err(d_err_o[0]), .wr_count(wr_count_o[0])
    );

    dual_port_mem_model #(.ADDR_W(16), .DATA_W(32), .RD_LAT(3), .RESET_INSTR(32'hC8000000)) u_dut3 (
        .mem_clk(mem_clk), .nreset(nreset),
        .i_en(i_en), .i_addr(i_addr), .i_rdata(i_rdata_o[1]), .i_valid(i_valid_o[1]),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata_o[1]), .d_valid(d_valid_o[1]), .d_err(d_err_o[1]), .wr_count(wr_count_o[1])
    );

    always #5 mem_clk = ~mem_clk;

    always @(posedge mem_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s dut%0d cyc=%0d: got %h expected %h", name, k, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        logic [31:0] w;
        logic [15:0] b;
        for (int k = 0; k < 4; k++) begin
            b = a[15:0] + 16'(k);
            w[8*k +: 8] = mdl[b];
        end
        return w;
    endfunction

    // One clock of stimulus: drive for the coming edge and record what the
    // spec says that edge must produce.
    task automatic step(input bit ien, input logic [31:0] ia, input bit rd, input bit wr,
                        input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be);
        int c;
        logic [15:0] b;
        @(negedge mem_clk);
        #1;
        if (hold_rst) begin
            nreset = 1'b0;
            i_exp.delete();
            d_exp.delete();
            e_exp.delete();
            mdl_wr = '0;
        end else begin
            nreset = 1'b1;
        end
        i_en = ien; i_addr = ia; d_read = rd; d_write = wr;
        d_addr = da; d_wdata = wd; d_be = be;
        c = cyc + 1;
        if (!hold_rst) begin
            if (ien) i_exp[c] = mdl_rd(ia);
            if (rd && !wr) d_exp[c] = mdl_rd(da);
            if (rd && wr) e_exp[c+1] = 1'b1;
            if (wr) begin
                for (int k = 0; k < 4; k++) begin
                    b = da[15:0] + 16'(k);
                    if (be[k]) mdl[b] = wd[8*k +: 8];
                end
                if (be != 4'd0) mdl_wr = mdl_wr + 32'd1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0, 4'd0);
    endtask

    // Monitor
    always @(negedge mem_clk) begin
        int lat;
        for (int k = 0; k < 2; k++) begin
            lat = (k == 0) ? 1 : 3;
            if (!nreset) begin
                last_i[k] = 32'hC8000000;
                last_d[k] = '0;
                chk("rst_i_rdata", k, i_rdata_o[k], 32'hC8000000);
                chk("rst_i_valid", k, 32'(i_valid_o[k]), 32'd0);
                chk("rst_d_rdata", k, d_rdata_o[k], 32'd0);
                chk("rst_d_valid", k, 32'(d_valid_o[k]), 32'd0);
                chk("rst_d_err", k, 32'(d_err_o[k]), 32'd0);
                chk("rst_wr_count", k, wr_count_o[k], 32'd0);
            end else begin
                if (i_exp.exists(cyc - lat)) begin
                    chk("i_valid", k, 32'(i_valid_o[k]), 32'd1);
                    chk("i_rdata", k, i_rdata_o[k], i_exp[cyc - lat]);
                    last_i[k] = i_exp[cyc - lat];
                end else begin
                    chk("i_valid_idle", k, 32'(i_valid_o[k]), 32'd0);
                    chk("i_rdata_hold", k, i_rdata_o[k], last_i[k]);
                end
                if (d_exp.exists(cyc - lat)) begin
                    chk("d_valid", k, 32'(d_valid_o[k]), 32'd1);
                    chk("d_rdata", k, d_rdata_o[k], d_exp[cyc - lat]);
                    last_d[k] = d_exp[cyc - lat];
                end else begin
                    chk("d_valid_idle", k, 32'(d_valid_o[k]), 32'd0);
                    chk("d_rdata_hold", k, d_rdata_o[k], last_d[k]);
                end
                chk("d_err", k, 32'(d_err_o[k]), e_exp.exists(cyc) ? 32'd1 : 32'd0);
                chk("wr_count", k, wr_count_o[k], mdl_wr);
            end
        end
        if (i_exp.exists(cyc - 3)) i_exp.delete(cyc - 3);
        if (d_exp.exists(cyc - 3)) d_exp.delete(cyc - 3);
        if (e_exp.exists(cyc)) e_exp.delete(cyc);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] a;
        bit          ien, rd, wr;

        // Power-up reset, then fill every byte through the write port.
        hold_rst = 1'b1;
        idle(2);
        hold_rst = 1'b0;
        for (int i = 0; i < 16384; i++) begin
            a = 32'(i) * 4;
            w = $urandom;
            if (a == 32'h0) w = 32'h12345678;
            if (a == 32'h100) w = 32'h11223344;
            step(1'b0, '0, 1'b0, 1'b1, a, w, 4'hF);
        end

        // Reset with fetch requests held high; memory must survive.
        hold_rst = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            chk("dir_rst_i_rdata", k, i_rdata_o[k], 32'hC8000000);
            chk("dir_rst_wr_count", k, wr_count_o[k], 32'd0);
        end
        hold_rst = 1'b0;
        step(1'b1, 32'h0, 1'b0, 1'b0, '0, '0, 4'd0);
        idle(4);
        for (int k = 0; k < 2; k++) chk("dir_fetch0", k, i_rdata_o[k], 32'h12345678);

        // Byte-enable write
        step(1'b0, '0, 1'b0, 1'b1, 32'h100, 32'hAABBCCDD, 4'b0101);
        step(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 4'd0);
        idle(4);
        for (int k = 0; k < 2; k++) begin
            chk("dir_be_rdata", k, d_rdata_o[k], 32'h11BB33DD);
            chk("dir_be_wr_count", k, wr_count_o[k], 32'd1);
        end

        // Wrap at the top of memory, unaligned
        step(1'b0, '0, 1'b0, 1'b1, 32'hFFFE, 32'hCAFEBABE, 4'hF);
        step(1'b0, '0, 1'b1, 1'b0, 32'h0000, '0, 4'd0);
        idle(4);
        for (int k = 0; k < 2; k++) chk("dir_wrap_lo", k, d_rdata_o[k], 32'h1234CAFE);
        step(1'b0, '0, 1'b1, 1'b0, 32'h0001_FFFE, '0, 4'd0);
        idle(4);
        for (int k = 0; k < 2; k++) begin
            chk("dir_wrap_hi", k, d_rdata_o[k], 32'hCAFEBABE);
            chk("dir_wrap_wr_count", k, wr_count_o[k], 32'd2);
        end

        // Collision: write wins, read dropped, d_err one cycle later
        step(1'b0, '0, 1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
        step(1'b0, '0, 1'b1, 1'b0, 32'h20, '0, 4'd0);
        idle(1);
        for (int k = 0; k < 2; k++) chk("dir_coll_err", k, 32'(d_err_o[k]), 32'd1);
        chk("dir_coll_novalid", 0, 32'(d_valid_o[0]), 32'd0);
        idle(1);
        chk("dir_coll_err_end", 0, 32'(d_err_o[0]), 32'd0);
        chk("dir_coll_rdata", 0, d_rdata_o[0], 32'h5);
        idle(3);
        for (int k = 0; k < 2; k++) chk("dir_coll_wr_count", k, wr_count_o[k], 32'd3);

        // Back-to-back reads
        for (int i = 0; i < 24; i++) step(1'b0, '0, 1'b1, 1'b0, $urandom, '0, 4'd0);
        idle(4);

        // Same-edge fetch/write hazard
        step(1'b1, 32'h40, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        step(1'b1, 32'h40, 1'b0, 1'b0, '0, '0, 4'd0);
        idle(4);
        for (int k = 0; k < 2; k++) chk("dir_hazard_new", k, i_rdata_o[k], 32'hDEADBEEF);

        // Reset while a read is in flight
        step(1'b0, '0, 1'b1, 1'b0, 32'h100, '0, 4'd0);
        idle(1);
        hold_rst = 1'b1;
        idle(2);
        hold_rst = 1'b0;
        idle(5);
        for (int k = 0; k < 2; k++) begin
            chk("dir_midrst_rdata", k, d_rdata_o[k], 32'd0);
            chk("dir_midrst_valid", k, 32'(d_valid_o[k]), 32'd0);
        end

        // Random traffic on both ports
        for (int i = 0; i < 3000; i++) begin
            ien = 1'($urandom % 2);
            rd  = ($urandom % 3) == 0;
            wr  = ($urandom % 3) == 0;
            a   = $urandom;
            if (($urandom % 4) == 0) a = {a[31:16], 16'hFFFC + 16'($urandom % 4)};
            step(ien, ($urandom % 2) ? a : $urandom, rd, wr, a, $urandom, 4'($urandom % 16));
        end
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
